char_checker: RTL and testbench

//  Receive-side counterpart of the serial-test character generator. Consumes the 12-bit words
//  a UART receiver delivers and checks them against the test stream:

---
 rtl/char_checker_if.sv | 9 +
 rtl/char_checker.sv | 181 ++++++++++++++++++
 tb/tb_char_checker.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_checker_if.sv
// Receiver-to-checker character handshake: level flag plus data, with a clear pulse back.
interface char_checker_if;
    logic        char_ready;
    logic [0:11] rx_char;
    logic        char_clear;

    modport master (output char_ready, output rx_char, input char_clear);
    modport slave  (input char_ready, input rx_char, output char_clear);
endinterface

// File: rtl/char_checker.sv
// Checks a received serial-test character stream (ascending printable lines + CR/LF).
// Optional macro CHAR_CHECK_CAPTURE_EN keeps the expected/received pair of the first error.
module char_checker #(
    parameter int unsigned LINE_LEN   = 80,
    parameter logic [6:0]  FIRST_CHAR = 7'o040,
    parameter logic [6:0]  CR_CODE    = 7'o015,
    parameter logic [6:0]  LF_CODE    = 7'o012
) (
    input  logic             clock,
    input  logic             reset,
    char_checker_if.slave    rx,
    output logic             locked,
    output logic             err,
    output logic [15:0]      good_count,
    output logic [7:0]       err_count,
    output logic [11:0]      line_count,
    output logic [6:0]       err_exp,
    output logic [6:0]       err_got
);

    localparam logic [6:0] LastCol = 7'(LINE_LEN - 1);

    typedef enum logic [2:0] {StHunt, StHuntLf, StChkChar, StChkCr, StChkLf} state_e;

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [6:0]  exp_q, exp_d;
    logic [1:0]  holdoff_q, holdoff_d;
    logic        clear_q, clear_d;
    logic        err_q, err_d;
    logic        locked_q, locked_d;
    logic [15:0] good_q, good_d;
    logic [7:0]  errc_q, errc_d;
    logic [11:0] line_q, line_d;

    logic        accept;
    logic        mismatch;
    logic [6:0]  c;
    logic [6:0]  want;
    logic        unused_rx_bits;

    assign c              = rx.rx_char[5:11];
    assign unused_rx_bits = ^rx.rx_char[0:4];
    assign accept         = rx.char_ready && (holdoff_q == 2'd0);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        exp_d     = exp_q;
        holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
        clear_d   = 1'b0;
        err_d     = 1'b0;
        good_d    = good_q;
        errc_d    = errc_q;
        line_d    = line_q;
        mismatch  = 1'b0;
        want      = exp_q;

        if (accept) begin
            // Holdoff covers the clear cycle plus one so the receiver can drop its flag.
            holdoff_d = 2'd2;
            clear_d   = 1'b1;
            unique case (state_q)
                StHunt: begin
                    if (c == CR_CODE) state_d = StHuntLf;
                end
                StHuntLf: begin
                    if (c == LF_CODE) begin
                        state_d = StChkChar;
                        col_d   = 7'd0;
                        exp_d   = FIRST_CHAR;
                    end else if (c != CR_CODE) begin
                        state_d = StHunt;
                    end
                end
                StChkChar: begin
                    want = exp_q;
                    if (c == exp_q) begin
                        good_d = good_q + 16'd1;
                        col_d  = col_q + 7'd1;
                        exp_d  = exp_q + 7'd1;
                        if (col_q == LastCol) state_d = StChkCr;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                StChkCr: begin
                    want = CR_CODE;
                    if (c == CR_CODE) begin
                        good_d  = good_q + 16'd1;
                        state_d = StChkLf;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                StChkLf: begin
                    want = LF_CODE;
                    if (c == LF_CODE) begin
                        good_d  = good_q + 16'd1;
                        line_d  = line_q + 12'd1;
                        col_d   = 7'd0;
                        exp_d   = FIRST_CHAR;
                        state_d = StChkChar;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase

            if (mismatch) begin
                err_d   = 1'b1;
                errc_d  = (errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
                // A stray CR already counts as the first half of a resync.
                state_d = (c == CR_CODE) ? StHuntLf : StHunt;
            end
        end

        locked_d = (state_d == StChkChar) || (state_d == StChkCr) || (state_d == StChkLf);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StHunt;
            col_q     <= 7'd0;
            exp_q     <= FIRST_CHAR;
            holdoff_q <= 2'd0;
            clear_q   <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            good_q    <= 16'd0;
            errc_q    <= 8'd0;
            line_q    <= 12'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            exp_q     <= exp_d;
            holdoff_q <= holdoff_d;
            clear_q   <= clear_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            good_q    <= good_d;
            errc_q    <= errc_d;
            line_q    <= line_d;
        end
    end

`ifdef CHAR_CHECK_CAPTURE_EN
    logic       cap_done_q;
    logic [6:0] cap_exp_q;
    logic [6:0] cap_got_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_done_q <= 1'b0;
            cap_exp_q  <= 7'd0;
            cap_got_q  <= 7'd0;
        end else if (accept && mismatch && !cap_done_q) begin
            cap_done_q <= 1'b1;
            cap_exp_q  <= want;
            cap_got_q  <= c;
        end
    end

    assign err_exp = cap_exp_q;
    assign err_got = cap_got_q;
`else
    logic [6:0] unused_want;
    assign unused_want = want;
    assign err_exp     = 7'd0;
    assign err_got     = 7'd0;
`endif

    assign rx.char_clear = clear_q;
    assign locked        = locked_q;
    assign err           = err_q;
    assign good_count    = good_q;
    assign err_count     = errc_q;
    assign line_count    = line_q;

endmodule

// File: tb/tb_char_checker.sv
// Scoreboard bench for char_checker: directed character vectors, expected results queued per accept.
module tb_char_checker;

    localparam logic [6:0] CR = 7'o015;
    localparam logic [6:0] LF = 7'o012;
    localparam logic [6:0] FC = 7'o040;

    typedef enum int {KHunt, KGood, KGoodLine, KBad} kind_e;

    typedef struct {
        int          id;
        logic        err;
        logic        locked;
        logic [15:0] good;
        logic [7:0]  errc;
        logic [11:0] line;
        logic [6:0]  eexp;
        logic [6:0]  egot;
    } rec_t;

    logic        clock;
    logic        reset;
    logic        locked;
    logic        err;
    logic [15:0] good_count;
    logic [7:0]  err_count;
    logic [11:0] line_count;
    logic [6:0]  err_exp;
    logic [6:0]  err_got;

    char_checker_if cif ();

    char_checker dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (cif.slave),
        .locked     (locked),
        .err        (err),
        .good_count (good_count),
        .err_count  (err_count),
        .line_count (line_count),
        .err_exp    (err_exp),
        .err_got    (err_got)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    int   next_id = 0;
    rec_t sb[$];

    // Hand-tracked expectation state, stepped only by the labelled outcome of each vector.
    logic [15:0] e_good = 0;
    logic [7:0]  e_errc = 0;
    logic [11:0] e_line = 0;
    logic [6:0]  e_exp  = 0;
    logic [6:0]  e_got  = 0;
    bit          e_capd = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [6:0] c, input kind_e kind, input bit lock_after,
                            input logic [6:0] want);
        rec_t r;
        case (kind)
            KGood:     e_good++;
            KGoodLine: begin e_good++; e_line++; end
            KBad: begin
                if (e_errc != 8'hFF) e_errc++;
                if (!e_capd) begin
                    e_capd = 1;
                    e_exp  = want;
                    e_got  = c;
                end
            end
            default: ;
        endcase
        r.id     = next_id++;
        r.err    = (kind == KBad);
        r.locked = lock_after;
        r.good   = e_good;
        r.errc   = e_errc;
        r.line   = e_line;
`ifdef CHAR_CHECK_CAPTURE_EN
        r.eexp   = e_exp;
        r.egot   = e_got;
`else
        r.eexp   = 7'd0;
        r.egot   = 7'd0;
`endif
        sb.push_back(r);
    endtask

    // Present one char like a receiver: flag stays up until char_clear is seen.
    task automatic drive(input logic [6:0] c);
        bit seen = 0;
        cif.rx_char    = {5'b0, c};
        cif.char_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (cif.char_clear) seen = 1;
        end
        cif.char_ready = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: char %0o got no char_clear within 20 cycles", c);
        end
    endtask

    task automatic send(input logic [6:0] c, input kind_e kind, input bit lock_after,
                        input logic [6:0] want);
        push_exp(c, kind, lock_after, want);
        drive(c);
    endtask

    task automatic idle(input int n);
        cif.char_ready = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_clear"}, int'(cif.char_clear), 0);
        chk({tag, "_good"}, int'(good_count), 0);
        chk({tag, "_errc"}, int'(err_count), 0);
        chk({tag, "_line"}, int'(line_count), 0);
        chk({tag, "_eexp"}, int'(err_exp), 0);
        chk({tag, "_egot"}, int'(err_got), 0);
    endtask

    // Monitor: every char_clear pulse is one accept and retires one expected record.
    always @(negedge clock) begin
        if (cif.char_clear) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_clear: got char_clear with empty scoreboard");
            end else begin
                rec_t r;
                r = sb.pop_front();
                if (err !== r.err || locked !== r.locked || good_count !== r.good ||
                    err_count !== r.errc || line_count !== r.line ||
                    err_exp !== r.eexp || err_got !== r.egot) begin
                    bad++;
                    $display("FAIL accept#%0d: got err=%0b lock=%0b good=%0d errc=%0d line=%0d eexp=%0o egot=%0o want err=%0b lock=%0b good=%0d errc=%0d line=%0d eexp=%0o egot=%0o",
                             r.id, err, locked, good_count, err_count, line_count, err_exp,
                             err_got, r.err, r.locked, r.good, r.errc, r.line, r.eexp, r.egot);
                end
            end
        end else begin
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL err_without_clear: got err=%b want 0", err);
            end
        end
    end

    initial begin
        int clears;
        int last_clear;
        int gap_bad;

        reset          = 1'b1;
        cif.char_ready = 1'b0;
        cif.rx_char    = '0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Test 1: acquire lock and check one full line.
        send(CR, KHunt, 0, 0);
        send(LF, KHunt, 1, 0);
        for (int i = 0; i < 80; i++) send(7'(FC + i), KGood, 1, 0);
        send(CR, KGood, 1, 0);
        send(LF, KGoodLine, 1, 0);
        idle(3);
        chk("t1_good", int'(good_count), 82);
        chk("t1_line", int'(line_count), 1);
        chk("t1_errc", int'(err_count), 0);
        chk("t1_locked", int'(locked), 1);

        // Test 2: mismatch at col 5.
        for (int i = 0; i < 5; i++) send(7'(FC + i), KGood, 1, 0);
        send(7'o130, KBad, 0, 7'o045);
        idle(3);
        chk("t2_errc", int'(err_count), 1);
        chk("t2_locked", int'(locked), 0);

        // Test 3: CR,CR at end of line resyncs straight into HUNT_LF.
        send(CR, KHunt, 0, 0);
        send(LF, KHunt, 1, 0);
        for (int i = 0; i < 80; i++) send(7'(FC + i), KGood, 1, 0);
        send(CR, KGood, 1, 0);
        send(CR, KBad, 0, LF);
        send(LF, KHunt, 1, 0);
        send(FC, KGood, 1, 0);
        idle(3);
        chk("t3_good", int'(good_count), 169);
        chk("t3_errc", int'(err_count), 2);
        chk("t3_line", int'(line_count), 1);

        // Test 4a: flag held 3 cycles gives exactly one clear, one cycle after accept.
        idle(3);
        push_exp(7'o041, KGood, 1, 0);
        cif.rx_char    = {5'b0, 7'o041};
        cif.char_ready = 1'b1;
        clears = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            if (i == 1) chk("t4_clear_latency", int'(cif.char_clear), 1);
            if (cif.char_clear) clears++;
        end
        cif.char_ready = 1'b0;
        chk("t4_single_clear", clears, 1);

        // Test 4b: flag held 10 cycles re-accepts exactly every 3 cycles.
        idle(3);
        push_exp(7'o132, KBad, 0, 7'o042);
        for (int i = 0; i < 3; i++) push_exp(7'o132, KHunt, 0, 0);
        cif.rx_char    = {5'b0, 7'o132};
        cif.char_ready = 1'b1;
        clears     = 0;
        last_clear = -1;
        gap_bad    = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (cif.char_clear) begin
                if (last_clear >= 0 && i - last_clear != 3) gap_bad++;
                last_clear = i;
                clears++;
            end
        end
        cif.char_ready = 1'b0;
        chk("t4_hold_clears", clears, 4);
        chk("t4_hold_gap", gap_bad, 0);
        idle(3);

        // Test 5: error counter saturates.
        for (int i = 0; i < 300; i++) begin
            send(CR, KHunt, 0, 0);
            send(LF, KHunt, 1, 0);
            send(7'o132, KBad, 0, FC);
        end
        idle(3);
        chk("t5_errc_sat", int'(err_count), 255);
        chk("t5_good_kept", int'(good_count), 170);

        // Test 6: reset mid-line with a char pending.
        send(CR, KHunt, 0, 0);
        send(LF, KHunt, 1, 0);
        send(FC, KGood, 1, 0);
        send(7'o041, KGood, 1, 0);
        @(negedge clock);
        reset          = 1'b1;
        cif.rx_char    = {5'b0, 7'o042};
        cif.char_ready = 1'b1;
        @(negedge clock);
        chk_all_zero("t6_reset");
        e_good = 0;
        e_errc = 0;
        e_line = 0;
        e_exp  = 0;
        e_got  = 0;
        e_capd = 0;
        push_exp(7'o042, KHunt, 0, 0);
        reset = 1'b0;
        drive(7'o042);
        send(CR, KHunt, 0, 0);
        send(LF, KHunt, 1, 0);
        send(FC, KGood, 1, 0);
        idle(3);
        chk("t6_good", int'(good_count), 1);
        chk("t6_locked", int'(locked), 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
